// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 8x8 multiplier: widths, sequencer
// states, step codes and the per-step shift amount.
package mult_pkg;

    localparam int unsigned WIDTH_IN  = 8;
    localparam int unsigned WIDTH_OUT = 2 * WIDTH_IN;
    localparam int unsigned NIB_W     = WIDTH_IN / 2;
    localparam int unsigned PP_W      = 2 * NIB_W;
    localparam int unsigned STEP_W    = 2;
    localparam int unsigned SHIFT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Step code: bit 0 selects the high nibble of a, bit 1 the high nibble of b.
    localparam logic [STEP_W-1:0] STEP_LL = 2'd0;
    localparam logic [STEP_W-1:0] STEP_HL = 2'd1;
    localparam logic [STEP_W-1:0] STEP_LH = 2'd2;
    localparam logic [STEP_W-1:0] STEP_HH = 2'd3;

    localparam logic [SHIFT_W-1:0] SHIFT_0 = 4'd0;
    localparam logic [SHIFT_W-1:0] SHIFT_4 = 4'd4;
    localparam logic [SHIFT_W-1:0] SHIFT_8 = 4'd8;

    function automatic logic [SHIFT_W-1:0] step_shift(input logic [STEP_W-1:0] step);
        case (step)
            STEP_LL: step_shift = SHIFT_0;
            STEP_HH: step_shift = SHIFT_8;
            default: step_shift = SHIFT_4;
        endcase
    endfunction

endpackage

// File: rtl/mult4x4.sv
// Combinational 4x4 unsigned multiplier producing an 8-bit partial product.
module mult4x4
    import mult_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    output logic [PP_W-1:0]  p_o
);

    assign p_o = PP_W'(a_i) * PP_W'(b_i);

endmodule

// File: rtl/mult8x8_seq_ctrl.sv
// Sequential 8x8 multiplier: latches operands on start, accumulates four 4x4
// partial products over four RUN cycles, then pulses done with the product.
module mult8x8_seq_ctrl
    import mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 sclr,
    input  logic                 start,
    input  logic [WIDTH_IN-1:0]  dataa,
    input  logic [WIDTH_IN-1:0]  datab,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH_OUT-1:0] product,
    output logic [STEP_W-1:0]    step_count
);

    state_e               state_q, state_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [WIDTH_IN-1:0]  a_q, a_d;
    logic [WIDTH_IN-1:0]  b_q, b_d;
    logic [WIDTH_OUT-1:0] acc_q, acc_d;
    logic [WIDTH_OUT-1:0] product_q, product_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [NIB_W-1:0]     nib_a, nib_b;
    logic [PP_W-1:0]      pp;
    logic [WIDTH_OUT-1:0] pp_shifted;
    logic [WIDTH_OUT-1:0] acc_sum;

    // Nibble selection, partial product and alignment for the current step
    assign nib_a      = step_q[0] ? a_q[WIDTH_IN-1:NIB_W] : a_q[NIB_W-1:0];
    assign nib_b      = step_q[1] ? b_q[WIDTH_IN-1:NIB_W] : b_q[NIB_W-1:0];
    assign pp_shifted = WIDTH_OUT'(pp) << step_shift(step_q);
    assign acc_sum    = acc_q + pp_shifted;

    mult4x4 u_mult4x4 (
        .a_i (nib_a),
        .b_i (nib_b),
        .p_o (pp)
    );

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q   <= ST_IDLE;
            step_q    <= STEP_LL;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state and datapath updates; DONE accepts start just like IDLE
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = dataa;
                    b_d     = datab;
                    acc_d   = '0;
                    step_d  = STEP_LL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d  = acc_sum;
                step_d = step_q + 2'd1;
                if (step_q == STEP_HH) begin
                    state_d   = ST_DONE;
                    product_d = acc_sum;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                step_d    = STEP_LL;
                a_d       = '0;
                b_d       = '0;
                acc_d     = '0;
                product_d = '0;
            end
        endcase
    end

    // Registered status flags follow the state being entered
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign product    = product_q;
    assign step_count = step_q;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Self-checking bench for mult8x8_seq_ctrl: directed cases plus randomized
// operands checked against plain a*b and the start->done timing.
module tb_mult8x8_seq_ctrl;

    logic        clk = 1'b0;
    logic        sclr;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [1:0]  step_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] last_prod = 16'h0;
    bit          mon_en = 1'b0;
    logic        sclr_edge = 1'b1;
    logic        done_prev = 1'b0;
    logic [15:0] prod_prev = 16'h0;

    mult8x8_seq_ctrl dut (
        .clk        (clk),
        .sclr       (sclr),
        .start      (start),
        .dataa      (dataa),
        .datab      (datab),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) sclr_edge <= sclr;

    // done must never last two cycles; product may only move with done or reset
    always @(negedge clk) begin
        if (mon_en) begin
            check("done_single", 32'(done && done_prev), 32'd0);
            check("prod_only_on_done", 32'((product !== prod_prev) && !done && !sclr_edge), 32'd0);
        end
        done_prev = done;
        prod_prev = product;
    end

    task automatic idle_cycle();
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_step", 32'(step_count), 32'd0);
        check("idle_prod", 32'(product), 32'(last_prod));
    endtask

    // One operation: accept at edge k, four RUN cycles, done after edge k+4.
    // junk scrambles inputs during RUN; keep leaves start high for back-to-back.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit junk, input bit keep);
        logic [15:0] exp;
        exp   = 16'(a) * 16'(b);
        start = 1'b1;
        dataa = a;
        datab = b;
        @(posedge clk); #1;
        start = keep;
        for (int i = 0; i < 4; i++) begin
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            check("run_step", 32'(step_count), 32'(i));
            check("run_prod_hold", 32'(product), 32'(last_prod));
            if (junk) begin
                dataa = 8'($urandom);
                datab = 8'($urandom);
                if (!keep) start = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_step", 32'(step_count), 32'd0);
        check("done_prod", 32'(product), 32'(exp));
        last_prod = exp;
        start     = keep;
    endtask

    initial begin
        bit          keep;
        logic [7:0]  ra;
        logic [7:0]  rb;
        sclr  = 1'b1;
        start = 1'b0;
        dataa = 8'h0;
        datab = 8'h0;

        // Reset for two cycles
        repeat (2) @(posedge clk);
        #1;
        sclr = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_prod", 32'(product), 32'h0000);
        check("rst_step", 32'(step_count), 32'd0);
        last_prod = 16'h0;
        mon_en    = 1'b1;
        idle_cycle();

        // Basic products
        run_op(8'h12, 8'h34, 1'b0, 1'b0);
        check("p_12x34", 32'(product), 32'h03A8);
        idle_cycle();
        idle_cycle();
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        check("p_FFxFF", 32'(product), 32'hFE01);
        idle_cycle();
        run_op(8'h00, 8'hA5, 1'b0, 1'b0);
        check("p_00xA5", 32'(product), 32'h0000);
        idle_cycle();

        // Back-to-back with start held high
        run_op(8'h0F, 8'h10, 1'b0, 1'b1);
        check("p_0Fx10", 32'(product), 32'h00F0);
        run_op(8'h80, 8'h02, 1'b0, 1'b0);
        check("p_80x02", 32'(product), 32'h0100);
        idle_cycle();

        // start and operand changes during RUN are ignored
        run_op(8'h5A, 8'hC3, 1'b1, 1'b0);
        check("p_5AxC3", 32'(product), 32'h448E);
        idle_cycle();
        idle_cycle();

        // sclr mid-run at step 2
        start = 1'b1;
        dataa = 8'hAB;
        datab = 8'hCD;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort_step0", 32'(step_count), 32'd0);
        @(posedge clk); #1;
        check("abort_step1", 32'(step_count), 32'd1);
        @(posedge clk); #1;
        check("abort_step2", 32'(step_count), 32'd2);
        sclr = 1'b1;
        @(posedge clk); #1;
        sclr = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_prod", 32'(product), 32'h0000);
        check("abort_step", 32'(step_count), 32'd0);
        last_prod = 16'h0;
        repeat (3) idle_cycle();
        run_op(8'hAB, 8'hCD, 1'b0, 1'b0);
        check("p_ABxCD", 32'(product), 32'h88EF);
        idle_cycle();

        // Randomized operands, gaps and back-to-back mixes
        for (int it = 0; it < 1000; it++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            keep = (it != 999) && ($urandom_range(0, 3) == 0);
            run_op(ra, rb, 1'($urandom_range(0, 1)), keep);
            if (!keep) repeat ($urandom_range(0, 2)) idle_cycle();
        end
        start = 1'b0;
        idle_cycle();
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
